rr_parity_scheduler: RTL and testbench

RR_PARITY_SCHEDULER -- requirements
Module: rr_parity_scheduler

---
 rtl/rr_parity_scheduler.sv | 142 ++++++++++++++
 tb/tb_rr_parity_scheduler.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/rr_parity_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : rr_parity_scheduler
// Description : Round-robin arbiter over 8 requesters that captures the
//               granted requester's data word and serially computes its parity.
//               Define ODD_PARITY_EN to report the inverted (odd) parity bit.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_parity_scheduler #(
    parameter int NREQ   = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [DATA_W-1:0] data_in,
    output logic [NREQ-1:0]   gnt,
    output logic [2:0]        gnt_idx,
    output logic              busy,
    output logic              done,
    output logic              parity_out,
    output logic [2:0]        done_idx
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_LAST_BIT = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [NREQ-1:0]    c_ONE_HOT0 = NREQ'(1);

`ifdef ODD_PARITY_EN
    localparam logic c_PARITY_INV = 1'b1;
`else
    localparam logic c_PARITY_INV = 1'b0;
`endif

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_CHECK = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_ptr;
    logic [NREQ-1:0]     r_gnt;
    logic [2:0]          r_gnt_idx;
    logic                r_busy;
    logic                r_done;
    logic                r_parity;
    logic [2:0]          r_done_idx;
    logic [DATA_W-1:0]   r_shift;
    logic                r_acc;
    logic [c_CNT_W-1:0]  r_cnt;

    logic [2:0]          w_rr_idx;
    logic [2:0]          w_cand;
    logic                w_acc_next;

    // Scan from farthest to nearest so the last hit is the first requester after ptr.
    always_comb begin
        w_rr_idx = r_ptr;
        w_cand   = r_ptr;
        for (int i = NREQ; i >= 1; i--) begin
            w_cand = r_ptr + 3'(i);
            if (req[w_cand]) begin
                w_rr_idx = w_cand;
            end
        end
    end

    assign w_acc_next = r_acc ^ r_shift[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_ptr      <= 3'd7;
            r_gnt      <= '0;
            r_gnt_idx  <= 3'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_parity   <= 1'b0;
            r_done_idx <= 3'd0;
            r_shift    <= '0;
            r_acc      <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (|req) begin
                        r_state   <= ST_GRANT;
                        r_gnt     <= c_ONE_HOT0 << w_rr_idx;
                        r_gnt_idx <= w_rr_idx;
                        r_busy    <= 1'b1;
                    end
                end
                ST_GRANT: begin
                    r_gnt <= '0;
                    if (req[r_gnt_idx]) begin
                        r_shift <= data_in;
                        r_acc   <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= ST_CHECK;
                    end else begin
                        // Withdrawn request: abandon quietly, pointer untouched.
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end
                end
                ST_CHECK: begin
                    r_acc   <= w_acc_next;
                    r_shift <= r_shift >> 1;
                    r_cnt   <= r_cnt + c_CNT_ONE;
                    if (r_cnt == c_LAST_BIT) begin
                        r_state    <= ST_DONE;
                        r_done     <= 1'b1;
                        r_parity   <= w_acc_next ^ c_PARITY_INV;
                        r_done_idx <= r_gnt_idx;
                    end
                end
                ST_DONE: begin
                    r_ptr   <= r_gnt_idx;
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign gnt        = r_gnt;
    assign gnt_idx    = r_gnt_idx;
    assign busy       = r_busy;
    assign done       = r_done;
    assign parity_out = r_parity;
    assign done_idx   = r_done_idx;

endmodule
`default_nettype wire

// File: tb/tb_rr_parity_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_rr_parity_scheduler
// Description : Self-checking bench for rr_parity_scheduler (vector table,
//               result scoreboard and hand-written corner sequences).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_parity_scheduler;

`ifdef ODD_PARITY_EN
    localparam logic c_INV = 1'b1;
`else
    localparam logic c_INV = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] req;
    logic [7:0] data_in;
    logic [7:0] gnt;
    logic [2:0] gnt_idx;
    logic       busy;
    logic       done;
    logic       parity_out;
    logic [2:0] done_idx;

    rr_parity_scheduler #(.NREQ(8), .DATA_W(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .data_in    (data_in),
        .gnt        (gnt),
        .gnt_idx    (gnt_idx),
        .busy       (busy),
        .done       (done),
        .parity_out (parity_out),
        .done_idx   (done_idx)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [2:0] idx;
        logic       par;
        int         cyc;
    } sb_t;

    typedef struct {
        logic [7:0] req;
        logic [7:0] data;
        logic [7:0] req2;
        logic [7:0] data2;
        logic [2:0] idx;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[9];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        sb_t e;
        if (done) begin
            if (sb_q.size() == 0) begin
                chk("spurious_done", 32'(done), 32'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done_idx", 32'(done_idx), 32'(e.idx));
                chk("parity_out", 32'(parity_out), 32'(e.par));
                chk("done_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic wait_idle();
        for (int i = 0; i < 40 && busy; i++) @(negedge clk);
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    // Drives one transaction; returns at the first CHECK cycle after applying req2/data2.
    task automatic do_txn(input vec_t v);
        sb_t e;
        wait_idle();
        req     = v.req;
        data_in = v.data;
        e.idx   = v.idx;
        e.par   = (^v.data) ^ c_INV;
        e.cyc   = cyc + 10;
        sb_q.push_back(e);
        @(negedge clk);
        chk("gnt", 32'(gnt), 32'(8'd1 << v.idx));
        chk("gnt_idx", 32'(gnt_idx), 32'(v.idx));
        chk("busy_grant", 32'(busy), 32'd1);
        @(negedge clk);
        chk("gnt_in_check", 32'(gnt), 32'd0);
        req     = v.req2;
        data_in = v.data2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_gnt"}, 32'(gnt), 32'd0);
        chk({tag, "_gnt_idx"}, 32'(gnt_idx), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_done"}, 32'(done), 32'd0);
        chk({tag, "_parity"}, 32'(parity_out), 32'd0);
        chk({tag, "_done_idx"}, 32'(done_idx), 32'd0);
    endtask

    initial begin
        vec_t v;
        logic [2:0] exp_idx;

        //          req     data    req2    data2   idx
        vecs[0] = '{8'h01, 8'hA5, 8'h01, 8'h5A, 3'd0};
        vecs[1] = '{8'hFF, 8'h3C, 8'hFF, 8'h00, 3'd0};
        vecs[2] = '{8'hFF, 8'h01, 8'hFF, 8'hFE, 3'd1};
        vecs[3] = '{8'hFF, 8'hFF, 8'h00, 8'h00, 3'd2};
        vecs[4] = '{8'h80, 8'h80, 8'h80, 8'h00, 3'd7};
        vecs[5] = '{8'h81, 8'h6B, 8'h81, 8'h00, 3'd0};
        vecs[6] = '{8'h81, 8'hC1, 8'h00, 8'h00, 3'd7};
        vecs[7] = '{8'h18, 8'h07, 8'h00, 8'h00, 3'd3};
        vecs[8] = '{8'h01, 8'h3C, 8'h00, 8'h00, 3'd0};

        rst = 1'b1; req = '0; data_in = '0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        rst = 1'b0;

        // Single requester, held
        do_txn(vecs[0]);
        wait_idle();
        req = '0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;

        // All requesters held: 0,1,2, then wrap-around cases
        for (int i = 1; i <= 6; i++) do_txn(vecs[i]);

        // Request withdrawn during GRANT (ptr is 7)
        wait_idle();
        req = 8'h08; data_in = 8'hFF;
        @(negedge clk);
        chk("wd_gnt", 32'(gnt), 32'h08);
        chk("wd_gnt_idx", 32'(gnt_idx), 32'd3);
        req = '0;
        @(negedge clk);
        chk("wd_busy", 32'(busy), 32'd0);
        chk("wd_gnt_after", 32'(gnt), 32'd0);

        // Old ptr=7 must pick 3 over 4; data changed and req dropped during CHECK
        do_txn(vecs[7]);

        // Reset in the middle of CHECK
        wait_idle();
        req = 8'h01; data_in = 8'hFF;
        repeat (4) @(negedge clk);
        rst = 1'b1; req = '0;
        @(negedge clk);
        chk_all_zero("midrst");
        rst = 1'b0;
        do_txn(vecs[8]);

        // Full rotation with all requests held
        exp_idx = 3'd0;
        for (int i = 0; i < 9; i++) begin
            exp_idx = exp_idx + 3'd1;
            v.req   = 8'hFF;
            v.data  = 8'($urandom);
            v.req2  = 8'hFF;
            v.data2 = 8'($urandom);
            v.idx   = exp_idx;
            do_txn(v);
        end
        wait_idle();
        req = '0;
        repeat (15) @(negedge clk);
        chk("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
